// File: rtl/npc_lsu.sv
// -----------------------------------------------------------------------------
// npc_lsu -- multi-cycle load/store unit for the npc core.
//
// Accepts one load or store from the execute stage (valid/ready). It drives a
// word-aligned request with byte mask and lane-shifted store data to a
// variable-latency memory port, and waits for the read data or write ack. It
// then returns the sign/zero-extended load result, or a fault, through a
// valid/ready response channel. Only one access is in flight at a time.
//
// Parameters:
//   XLEN   datapath width, 32 or 64
//   BYTES  byte lanes per word (XLEN/8)
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready      request handshake (ready only while idle)
//   req_store, req_funct3    access kind and RISC-V size/sign encoding
//   req_addr, req_wdata      byte address, right-aligned store data
//   resp_valid/resp_ready    response handshake (valid held until ready)
//   resp_rdata, resp_fault   extended load data (0 for stores/faults), fault
//   mem_req_valid/_ready     bus request handshake
//   mem_wen, mem_addr        write enable, word-aligned address
//   mem_wdata, mem_wmask     lane-shifted store data, byte enables
//   mem_resp_valid, mem_rdata  one-cycle read-data / write-ack pulse
//
// Build option:
//   NPC_LSU_MISALIGN_TRAP_EN  when defined, accesses whose address is not a
//                             multiple of their size fault without touching
//                             the bus. When undefined they are issued with the
//                             truncated mask, and loads see missing upper
//                             bytes as zero.
// -----------------------------------------------------------------------------
module npc_lsu #(
  parameter int XLEN  = 32,
  parameter int BYTES = XLEN / 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_store,
  input  logic [2:0]       req_funct3,
  input  logic [XLEN-1:0]  req_addr,
  input  logic [XLEN-1:0]  req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_rdata,
  output logic             resp_fault,
  output logic             mem_req_valid,
  input  logic             mem_req_ready,
  output logic             mem_wen,
  output logic [XLEN-1:0]  mem_addr,
  output logic [XLEN-1:0]  mem_wdata,
  output logic [BYTES-1:0] mem_wmask,
  input  logic             mem_resp_valid,
  input  logic [XLEN-1:0]  mem_rdata
);

  localparam int OFFW = $clog2(BYTES);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_RESP} state_t;

  state_t            state_q, state_d;
  logic              store_q, store_d;
  logic              unsigned_q, unsigned_d;
  logic [3:0]        nbytes_q, nbytes_d;
  logic [OFFW-1:0]   offset_q, offset_d;
  logic              resp_fault_q, resp_fault_d;
  logic [XLEN-1:0]   resp_rdata_q, resp_rdata_d;
  logic              mem_wen_q, mem_wen_d;
  logic [XLEN-1:0]   mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [BYTES-1:0]  mem_wmask_q, mem_wmask_d;

  // ---------------------------------------------------------------------------
  // Decode of the incoming request
  // ---------------------------------------------------------------------------
  logic [OFFW-1:0]  in_offset;
  logic [3:0]       in_nbytes;
  logic [BYTES-1:0] in_wmask;
  logic             in_legal;
  logic             in_misaligned;

  assign in_offset = req_addr[OFFW-1:0];
  assign in_nbytes = 4'd1 << req_funct3[1:0];

  always_comb begin
    in_legal = 1'b0;
    if (req_store) begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010: in_legal = 1'b1;
        3'b011:                 in_legal = (XLEN == 64);
        default:                in_legal = 1'b0;
      endcase
    end else begin
      case (req_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: in_legal = 1'b1;
        3'b011, 3'b110:                         in_legal = (XLEN == 64);
        default:                                in_legal = 1'b0;
      endcase
    end
  end

`ifdef NPC_LSU_MISALIGN_TRAP_EN
  // Size is a power of two, so addr mod size is just the low offset bits.
  assign in_misaligned = |(in_offset & OFFW'(in_nbytes - 4'd1));
`else
  assign in_misaligned = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Per-lane masks. Lanes past the top of the word simply never match, which
  // gives the truncated store mask for free.
  // ---------------------------------------------------------------------------
  logic [XLEN-1:0]  load_shifted;
  logic [XLEN-1:0]  load_keep;
  logic [BYTES-1:0] load_msb_sel;
  logic [BYTES-1:0] load_byte_msb;
  logic             load_sign;
  logic [XLEN-1:0]  load_ext;

  // Zero-filling shift: bytes missing above the word read as 0.
  assign load_shifted = mem_rdata >> {offset_q, 3'b000};

  genvar gi;
  generate
    for (gi = 0; gi < BYTES; gi++) begin : g_lane
      assign in_wmask[gi]          = (gi >= int'(in_offset)) &&
                                     (gi < int'(in_offset) + int'(in_nbytes));
      assign load_keep[8*gi +: 8]  = {8{gi < int'(nbytes_q)}};
      assign load_msb_sel[gi]      = (gi + 1 == int'(nbytes_q));
      assign load_byte_msb[gi]     = load_shifted[8*gi + 7];
    end
  endgenerate

  // Sign comes from the top bit of the last byte of the access size.
  assign load_sign = ~unsigned_q & (|(load_msb_sel & load_byte_msb));
  assign load_ext  = (load_shifted & load_keep) | (load_sign ? ~load_keep : '0);

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d      = state_q;
    store_d      = store_q;
    unsigned_d   = unsigned_q;
    nbytes_d     = nbytes_q;
    offset_d     = offset_q;
    resp_fault_d = resp_fault_q;
    resp_rdata_d = resp_rdata_q;
    mem_wen_d    = mem_wen_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_wmask_d  = mem_wmask_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          store_d      = req_store;
          unsigned_d   = req_funct3[2];
          nbytes_d     = in_nbytes;
          offset_d     = in_offset;
          resp_rdata_d = '0;
          if (!in_legal || in_misaligned) begin
            // Fault bypasses the bus entirely.
            resp_fault_d = 1'b1;
            state_d      = S_RESP;
          end else begin
            resp_fault_d = 1'b0;
            mem_wen_d    = req_store;
            mem_addr_d   = {req_addr[XLEN-1:OFFW], {OFFW{1'b0}}};
            mem_wdata_d  = req_wdata << {in_offset, 3'b000};
            mem_wmask_d  = req_store ? in_wmask : '0;
            state_d      = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (mem_resp_valid) begin
          resp_rdata_d = store_q ? '0 : load_ext;
          state_d      = S_RESP;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      store_q      <= 1'b0;
      unsigned_q   <= 1'b0;
      nbytes_q     <= 4'd0;
      offset_q     <= '0;
      resp_fault_q <= 1'b0;
      resp_rdata_q <= '0;
      mem_wen_q    <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
    end else begin
      state_q      <= state_d;
      store_q      <= store_d;
      unsigned_q   <= unsigned_d;
      nbytes_q     <= nbytes_d;
      offset_q     <= offset_d;
      resp_fault_q <= resp_fault_d;
      resp_rdata_q <= resp_rdata_d;
      mem_wen_q    <= mem_wen_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_wmask_q  <= mem_wmask_d;
    end
  end

  // Handshake outputs are pure decodes of the state register.
  assign req_ready     = (state_q == S_IDLE);
  assign mem_req_valid = (state_q == S_REQ);
  assign resp_valid    = (state_q == S_RESP);
  assign resp_rdata    = resp_rdata_q;
  assign resp_fault    = resp_fault_q;
  assign mem_wen       = mem_wen_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_wmask     = mem_wmask_q;

endmodule
